fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the write port of the async FIFO (`wdata`/`winc`/`wfull`, write clock domain) among NREQ serial-side requesters.
- Grant is held for a whole frame, delimited by `req_last`, so bytes from different requesters never interleave inside the FIFO.
- A watchdog releases a grant if its owner stalls mid-frame.
- Sits in the write clock domain, directly in front of the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width; must equal the FIFO DSIZE.
- TIMEOUT, 16, consecutive idle cycles of the granted requester before forced release; 0 disables the watchdog.
- TWIDTH, 5, watchdog counter width; must satisfy 2^TWIDTH > TIMEOUT.

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester data valid.
- req_last  input  NREQ  marks final beat of a frame; qualified by req_valid.
- req_data  input  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  per-requester accept.
- wdata  output  DSIZE  to FIFO wdata.
- winc  output  1  to FIFO winc.
- wfull  input  1  from FIFO wfull.
- grant  output  NREQ  one-hot current owner; all-zero when idle.
- busy  output  1  high in BUSY state.
- abort  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Clock and reset: one clock (`wclk`); reset (`wrst`) is asynchronous and active-high.
- Reset values (applied asynchronously): state=IDLE, grant=0, busy=0, abort=0, winc=0, req_ready=0, wdata=0, last_grant=NREQ-1 (so requester 0 has first priority), watchdog count=0.
- States:
  - IDLE: if any req_valid, pick the first set bit scanning from last_grant+1 upward, wrapping. Register grant and go to BUSY. Arbitration latency is 1 cycle; no transfer happens in IDLE.
  - BUSY, combinational outputs for owner g:
    - req_ready[g] = ~wfull; all other req_ready = 0.
    - wdata = req_data[g]; wdata = 0 when not BUSY.
    - winc = req_valid[g] & ~wfull.
  - BUSY, transfer (winc=1) with req_last[g]=1: last_grant<=g, grant<=0, go to IDLE. This leaves one bubble cycle between frames.
  - BUSY, transfer without last: stay in BUSY.
- wfull=1: no transfer and no state change; last beat is held; watchdog does not count, because req_valid is high.
- Watchdog, active only in BUSY with TIMEOUT != 0:
  - Count increments each cycle req_valid[g]=0 and clears on any cycle req_valid[g]=1.
  - When a cycle with req_valid[g]=0 occurs while count==TIMEOUT-1: last_grant<=g, go to IDLE, abort=1 for the following cycle.
  - A requester reasserting valid in that same cycle is not idle, so no abort occurs.
- Simultaneous requests in IDLE: only round-robin order decides. A requester just released is lowest priority for the next pick.
- A request appearing for the current owner after its last beat waits for a fresh arbitration.
- The frame owner is never preempted except by the watchdog.
- Reset mid-frame: winc and req_ready drop immediately (asynchronous). A partially written frame stays in the FIFO; framing recovery belongs to the reader.
- Invariants:
  - grant is one-hot or zero.
  - winc implies ~wfull.
  - winc implies exactly one req_ready is high.

Decomposition:
- Shared package/include fifo_arb_pkg:
  - state encoding constants ST_IDLE, ST_BUSY (1 bit);
  - default TIMEOUT;
  - data-slice helper macro for req_data indexing.
- One sub-module, rr_pick: combinational NREQ-wide round-robin picker. Inputs: request vector, last_grant index. Outputs: one-hot pick, binary index, any.

Test Plan:
- Reset then req_valid=4'b0101, each a 3-beat frame (0x11,0x12,0x13 / 0x31,0x32,0x33), wfull=0 -> grant=0001 one cycle after request; winc for 3 cycles with 0x11..0x13; one idle cycle; grant=0100, then 0x31..0x33.
- All four requesters holding single-beat frames continuously -> grant sequence 0001,0010,0100,1000,0001, each separated by one IDLE cycle; no requester served twice before the others.
- Requester 1 mid-frame, wfull=1 for 5 cycles during its last beat 0xA5 -> winc=0 and req_ready[1]=0 for those 5 cycles, no abort; 0xA5 written the cycle wfull falls, then IDLE.
- TIMEOUT=16, requester 2 sends 1 beat then drops valid -> on the 16th idle cycle the arbiter returns to IDLE, abort=1 exactly one cycle later, and requester 3 (pending) is granted next. Repeat with valid reasserted on idle cycle 16 -> no abort.
- Assert wrst for 1 ns mid-frame (asynchronous, between clock edges) -> winc, req_ready, grant and busy go 0 immediately; after release requester 0 wins first.
- TIMEOUT=0, owner idle for 100 cycles -> grant held, abort never asserted.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding, default watchdog timeout and req_data slice helper shared by fifo_wr_arb.
`ifndef FIFO_ARB_PKG_SV
`define FIFO_ARB_PKG_SV
`define ARB_SLICE(v, i, w) v[(i)*(w) +: (w)]
package fifo_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    localparam int DEF_TIMEOUT = 16;
endpackage
`endif

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first request strictly after i_last, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_pick,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_j;
    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_j    = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = IW'((int'(i_last) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any       = 1'b1;
                o_pick[w_j] = 1'b1;
                o_idx       = w_j;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: frame-granular round-robin arbiter in front of an async FIFO write port,
// with a watchdog that reclaims the grant from an owner that stalls mid-frame.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DSIZE   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TWIDTH  = 5
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [DSIZE-1:0]      wdata,
    output logic                  winc,
    input  logic                  wfull,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  abort
);
    localparam int IW = $clog2(NREQ);
    state_t            r_state, w_state_n;
    logic [NREQ-1:0]   r_grant, w_grant_n, w_pick;
    logic [IW-1:0]     r_gidx, w_gidx_n, r_last, w_last_n, w_pidx;
    logic [TWIDTH-1:0] r_cnt, w_cnt_n;
    logic              r_abort, w_abort_n, w_any, w_valid_g, w_to;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_idx  (w_pidx),
        .o_any  (w_any)
    );

    assign busy      = r_state == ST_BUSY;
    assign grant     = r_grant;
    assign abort     = r_abort;
    assign w_valid_g = req_valid[r_gidx];
    assign winc      = busy & w_valid_g & ~wfull;
    assign req_ready = (busy && !wfull) ? r_grant : '0;
    assign wdata     = busy ? `ARB_SLICE(req_data, r_gidx, DSIZE) : '0;
    // Idle means the owner itself drops valid; a full FIFO with valid held is not idle.
    assign w_to      = TIMEOUT != 0 && busy && !w_valid_g && r_cnt == TWIDTH'(TIMEOUT - 1);

    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        w_gidx_n  = r_gidx;
        w_last_n  = r_last;
        w_cnt_n   = '0;
        w_abort_n = 1'b0;
        if (!busy) begin
            if (w_any) begin
                w_state_n = ST_BUSY;
                w_grant_n = w_pick;
                w_gidx_n  = w_pidx;
            end
        end else if ((winc && req_last[r_gidx]) || w_to) begin
            w_state_n = ST_IDLE;
            w_grant_n = '0;
            w_last_n  = r_gidx;
            w_abort_n = w_to;
        end else begin
            w_cnt_n = (TIMEOUT == 0 || w_valid_g) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(NREQ - 1);
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_grant <= w_grant_n;
            r_gidx  <= w_gidx_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
            r_abort <= w_abort_n;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: queue-driven requesters, per-requester scoreboard and a frame-level
// round-robin/watchdog reference model checked every cycle by an independent monitor.
`timescale 1ns/1ps
module tb_fifo_wr_arb;
    localparam int TO = 16;
    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic        wfull;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic [7:0]  wdata;
    logic        winc, busy, abort;
    logic [3:0]  n_valid, n_ready, n_grant;
    logic [3:0]  n_last = 4'b0;
    logic [31:0] n_data = 32'hA1B2C3D4;
    logic [7:0]  n_wdata;
    logic        n_winc, n_busy, n_abort;
    logic [3:0]  stall;
    logic [8:0]  src_q [4][$];
    logic [8:0]  exp_q [4][$];
    int checks = 0;
    int errors = 0;
    int m_owner = -1;
    int m_last = 3;
    int m_idle = 0;
    bit m_abort = 1'b0;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(.NREQ(4), .DSIZE(8), .TIMEOUT(TO), .TWIDTH(5)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wdata(wdata), .winc(winc),
        .wfull(wfull), .grant(grant), .busy(busy), .abort(abort)
    );

    fifo_wr_arb #(.NREQ(4), .DSIZE(8), .TIMEOUT(0), .TWIDTH(5)) dut_nw (
        .wclk(wclk), .wrst(wrst), .req_valid(n_valid), .req_last(n_last),
        .req_data(n_data), .req_ready(n_ready), .wdata(n_wdata), .winc(n_winc),
        .wfull(wfull), .grant(n_grant), .busy(n_busy), .abort(n_abort)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_next(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < 4; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic drive();
        logic [3:0] v, l;
        logic [31:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++)
            if (src_q[i].size() > 0 && !stall[i]) begin
                v[i] = 1'b1;
                l[i] = src_q[i][0][8];
                d[i*8 +: 8] = src_q[i][0][7:0];
            end
        req_valid = v;
        req_last  = l;
        req_data  = d;
    endtask

    task automatic push_frame(int r, int len, logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            src_q[r].push_back({k == len - 1, base + 8'(k)});
            exp_q[r].push_back({k == len - 1, base + 8'(k)});
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge wclk);
        #2;
    endtask

    task automatic drain(string nm, int n);
        int k = 0;
        while (pending() != 0 && k < n) begin
            tick(1);
            k++;
        end
        tick(2);
        chk(nm, pending(), 0);
    endtask

    task automatic wait_size(string nm, int r, int sz);
        int k = 0;
        while (src_q[r].size() != sz && k < 30) begin
            tick(1);
            k++;
        end
        chk(nm, src_q[r].size(), sz);
    endtask

    // Requesters: pop a beat once the DUT accepted it, then present the next one.
    always begin
        logic [3:0] hs;
        @(negedge wclk);
        hs = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    end

    always @(posedge wrst) begin
        m_owner = -1;
        m_last  = 3;
        m_idle  = 0;
        m_abort = 1'b0;
    end

    // Monitor: reference model of frame ownership plus scoreboard pop on every write.
    always @(negedge wclk) begin
        int o;
        logic [3:0] eg;
        logic [8:0] e;
        bit xfer;
        if (!wrst) begin
            o    = m_owner;
            eg   = (o >= 0) ? 4'(1 << o) : 4'b0;
            xfer = o >= 0 && req_valid[o] && !wfull;
            chk("grant", grant, eg);
            chk("busy", busy, o >= 0);
            chk("abort", abort, m_abort);
            chk("winc", winc, xfer);
            chk("req_ready", req_ready, (o >= 0 && !wfull) ? eg : 4'b0);
            if (o < 0) chk("wdata_idle", wdata, 0);
            else if (!xfer) chk("wdata_hold", wdata, req_data[o*8 +: 8]);
            else if (exp_q[o].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: write %0h from %0d with nothing expected", wdata, o);
            end else begin
                e = exp_q[o].pop_front();
                chk("wdata", wdata, e[7:0]);
            end
            m_abort = 1'b0;
            if (o < 0) begin
                if (req_valid != 0) m_owner = rr_next(req_valid, m_last);
                m_idle = 0;
            end else if (xfer && req_last[o]) begin
                m_last = o; m_owner = -1; m_idle = 0;
            end else if (!req_valid[o]) begin
                if (m_idle == TO - 1) begin
                    m_last = o; m_owner = -1; m_abort = 1'b1; m_idle = 0;
                end else m_idle++;
            end else m_idle = 0;
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ab_k, na, held;
        wfull = 1'b0; stall = '0; n_valid = '0;
        drive();
        tick(2);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_winc", winc, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", wdata, 0);
        wrst = 1'b0;
        tick(1);
        // two 3-beat frames from requesters 0 and 2
        push_frame(0, 3, 8'h11);
        push_frame(2, 3, 8'h31);
        drain("drain_two_frames", 40);
        // everyone busy with single-beat frames
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 4; i++) push_frame(i, 1, 8'(8'h40 + rep * 16 + i));
        drain("drain_all_four", 60);
        // full FIFO while requester 1 holds its last beat
        push_frame(1, 3, 8'hA3);
        wait_size("full_setup", 1, 1);
        wfull = 1'b1;
        tick(5);
        chk("last_beat_held", src_q[1].size(), 1);
        wfull = 1'b0;
        drain("drain_full", 20);
        // owner 2 stalls mid-frame while 3 waits
        push_frame(2, 2, 8'hC0);
        push_frame(3, 1, 8'hD0);
        wait_size("wd_setup", 2, 1);
        stall[2] = 1'b1;
        drive();
        ab_k = 0;
        for (int k = 1; k <= 40 && ab_k == 0; k++) begin
            @(negedge wclk);
            if (abort) ab_k = k;
        end
        chk("abort_cycle", ab_k, 17);
        @(posedge wclk);
        #1;
        chk("grant_after_abort", grant, 4'b1000);
        #1;
        stall[2] = 1'b0;
        drive();
        drain("drain_wd", 40);
        // owner resumes on the 16th idle cycle: no abort
        push_frame(2, 2, 8'hE0);
        wait_size("wd2_setup", 2, 1);
        stall[2] = 1'b1;
        drive();
        tick(15);
        stall[2] = 1'b0;
        drive();
        na = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge wclk);
            na += int'(abort);
        end
        chk("no_abort_resume", na, 0);
        tick(1);
        drain("drain_wd2", 20);
        // asynchronous reset between edges mid-frame
        push_frame(1, 4, 8'h50);
        wait_size("rst_setup", 1, 3);
        #1;
        wrst = 1'b1;
        #0.2;
        chk("arst_winc", winc, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        #0.8;
        wrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        push_frame(1, 1, 8'h61);
        push_frame(0, 1, 8'h60);
        held = 0;
        for (int k = 0; k < 10 && grant == 0; k++) @(negedge wclk);
        chk("first_after_reset", grant, 4'b0001);
        tick(1);
        drain("drain_after_reset", 20);
        // randomized traffic with stalls and back-pressure
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0 && src_q[r].size() < 8)
                push_frame(r, $urandom_range(1, 4), 8'($urandom));
            for (int i = 0; i < 4; i++)
                stall[i] = stall[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            wfull = $urandom_range(0, 4) == 0;
            drive();
            tick(1);
        end
        stall = '0;
        wfull = 1'b0;
        drive();
        drain("drain_random", 400);
        // watchdog disabled: idle owner keeps the grant
        n_valid = 4'b0001;
        tick(2);
        n_valid = 4'b0000;
        held = 0;
        na = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge wclk);
            held += int'(n_grant == 4'b0001);
            na += int'(n_abort);
        end
        chk("nw_grant_held", held, 100);
        chk("nw_no_abort", na, 0);
        chk("scoreboard_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
